// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: pipelined approximate adder (exact, LOA, truncate, split-carry)
// with a stream-rate error monitor. The sum and error are computed at accept and
// carried through PIPE register stages. The whole pipe advances together.
module approx_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned ACC_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   cfg_mode_i,
  input  logic [$clog2(WIDTH+1)-1:0]   cfg_k_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_a_i,
  input  logic [WIDTH-1:0]             in_b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH:0]               out_sum_o,
  output logic [WIDTH:0]               out_exact_o,
  output logic                         out_err_o,
  input  logic                         stat_clear_i,
  output logic [ACC_W-1:0]             stat_samples_o,
  output logic [ACC_W-1:0]             stat_err_cnt_o,
  output logic [WIDTH:0]               stat_max_err_o,
  output logic [ACC_W-1:0]             stat_sum_err_o
);

  localparam int unsigned KW   = $clog2(WIDTH + 1);
  localparam int unsigned SW   = WIDTH + 1;
  localparam int unsigned AW1  = ACC_W + 1;
  localparam int unsigned LAST = PIPE - 1;

  logic adv_c, acc_c, hs_c;

  // Global stall: the pipe moves only when the output slot is free or being taken
  assign adv_c      = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv_c & ~rst_i;
  assign acc_c      = in_valid_i & in_ready_o;
  assign hs_c       = out_valid_o & out_ready_i;

  logic [KW-1:0]    k_c;
  logic [SW-1:0]    a_x, b_x, mask_c, hi_c, lo_c;
  logic [SW-1:0]    sum_d, exact_d, abs_d;
  logic [WIDTH-1:0] ab_sh_c;
  logic             cin_c;

  // Approximate and exact sums plus absolute error for the operand pair at the input
  always_comb begin
    k_c     = (cfg_k_i > KW'(WIDTH)) ? KW'(WIDTH) : cfg_k_i;
    a_x     = SW'(in_a_i);
    b_x     = SW'(in_b_i);
    mask_c  = (SW'(1) << k_c) - SW'(1);
    ab_sh_c = '0;
    cin_c   = 1'b0;
    if (k_c != '0) begin
      ab_sh_c = (in_a_i & in_b_i) >> (k_c - KW'(1));
      cin_c   = ab_sh_c[0];
    end
    exact_d = a_x + b_x;
    hi_c    = (a_x >> k_c) + (b_x >> k_c);
    lo_c    = '0;
    case (cfg_mode_i)
      2'd1: begin
        lo_c = (a_x | b_x) & mask_c;
        hi_c = hi_c + SW'(cin_c);
      end
      2'd2: lo_c = '0;
      2'd3: lo_c = exact_d & mask_c;
      default: begin
        lo_c = '0;
        hi_c = '0;
      end
    endcase
    sum_d = (cfg_mode_i == 2'd0) ? exact_d : ((hi_c << k_c) | lo_c);
    abs_d = (exact_d >= sum_d) ? (exact_d - sum_d) : (sum_d - exact_d);
  end

  logic [PIPE-1:0] vld_q, err_q;
  logic [SW-1:0]   sum_q   [PIPE];
  logic [SW-1:0]   exact_q [PIPE];
  logic [SW-1:0]   abs_q   [PIPE];

  // Result pipeline: load stage 0 on advance and shift older stages forward
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        sum_q[i]   <= '0;
        exact_q[i] <= '0;
        abs_q[i]   <= '0;
      end
    end else if (adv_c) begin
      vld_q[0]   <= acc_c;
      err_q[0]   <= (sum_d != exact_d);
      sum_q[0]   <= sum_d;
      exact_q[0] <= exact_d;
      abs_q[0]   <= abs_d;
      for (int i = 1; i < PIPE; i++) begin
        vld_q[i]   <= vld_q[i-1];
        err_q[i]   <= err_q[i-1];
        sum_q[i]   <= sum_q[i-1];
        exact_q[i] <= exact_q[i-1];
        abs_q[i]   <= abs_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[LAST];
  assign out_err_o   = err_q[LAST];
  assign out_sum_o   = sum_q[LAST];
  assign out_exact_o = exact_q[LAST];

  logic [ACC_W-1:0] samples_q, samples_d, err_cnt_q, err_cnt_d, sum_err_q, sum_err_d;
  logic [SW-1:0]    max_err_q, max_err_d;
  logic [AW1-1:0]   smp_ext_c, errc_ext_c, serr_ext_c;

  // Error statistics: saturating update on output handshake, clear has priority
  always_comb begin
    samples_d  = samples_q;
    err_cnt_d  = err_cnt_q;
    sum_err_d  = sum_err_q;
    max_err_d  = max_err_q;
    smp_ext_c  = AW1'(samples_q) + AW1'(1);
    errc_ext_c = AW1'(err_cnt_q) + AW1'(out_err_o);
    serr_ext_c = AW1'(sum_err_q) + AW1'(abs_q[LAST]);
    if (stat_clear_i) begin
      samples_d = '0;
      err_cnt_d = '0;
      sum_err_d = '0;
      max_err_d = '0;
    end else if (hs_c) begin
      samples_d = smp_ext_c[ACC_W]  ? '1 : smp_ext_c[ACC_W-1:0];
      err_cnt_d = errc_ext_c[ACC_W] ? '1 : errc_ext_c[ACC_W-1:0];
      sum_err_d = serr_ext_c[ACC_W] ? '1 : serr_ext_c[ACC_W-1:0];
      max_err_d = (abs_q[LAST] > max_err_q) ? abs_q[LAST] : max_err_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      sum_err_q <= '0;
      max_err_q <= '0;
    end else begin
      samples_q <= samples_d;
      err_cnt_q <= err_cnt_d;
      sum_err_q <= sum_err_d;
      max_err_q <= max_err_d;
    end
  end

  assign stat_samples_o = samples_q;
  assign stat_err_cnt_o = err_cnt_q;
  assign stat_sum_err_o = sum_err_q;
  assign stat_max_err_o = max_err_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Bench for approx_adder_pipe: directed steps plus random streams against an
// arithmetic reference model and a result queue.
module tb_approx_adder_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PIPE  = 2;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned KW    = $clog2(WIDTH + 1);
  localparam longint      SAT   = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [KW-1:0]    k;
  logic             in_valid, in_ready, out_valid, out_ready, out_err, stat_clear;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   out_sum, out_exact, max_err;
  logic [ACC_W-1:0] samples, err_cnt, sum_err;

  always #5 clk = ~clk;

  approx_adder_pipe #(.WIDTH(WIDTH), .PIPE(PIPE), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_mode_i(mode), .cfg_k_i(k),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(a), .in_b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_exact_o(out_exact), .out_err_o(out_err),
    .stat_clear_i(stat_clear), .stat_samples_o(samples), .stat_err_cnt_o(err_cnt),
    .stat_max_err_o(max_err), .stat_sum_err_o(sum_err)
  );

  typedef struct {
    longint sum;
    longint exact;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  longint m_samples = 0, m_errcnt = 0, m_sumerr = 0, m_maxerr = 0;
  bit     chk_stats = 1'b1;
  bit     holding = 1'b0;
  bit     last_acc = 1'b0;
  logic   last_in_ready;
  logic [WIDTH:0] hold_sum, hold_exact;
  int     recv = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split operands arithmetically into k-bit low part and upper part
  function automatic longint ref_sum(input int md, input int kin, input longint x, input longint y);
    int kk;
    longint p, xl, yl, xh, yh, c;
    kk = (kin > int'(WIDTH)) ? int'(WIDTH) : kin;
    p  = longint'(1) << kk;
    xl = x % p;  yl = y % p;
    xh = x / p;  yh = y / p;
    if (kk > 0) c = ((x >> (kk - 1)) & (y >> (kk - 1))) & 1;
    else        c = 0;
    case (md)
      0:       return x + y;
      1:       return (xh + yh + c) * p + (xl | yl);
      2:       return (xh + yh) * p;
      default: return (xh + yh) * p + ((xl + yl) % p);
    endcase
  endfunction

  function automatic longint sat_add(input longint v, input longint inc);
    return (v + inc > SAT) ? SAT : v + inc;
  endfunction

  task automatic drive(input bit v, input int md, input int kk, input longint x, input longint y);
    in_valid = v;
    mode     = 2'(md);
    k        = KW'(kk);
    a        = WIDTH'(x);
    b        = WIDTH'(y);
  endtask

  // One clock: observe handshakes at negedge, update the model, then step past posedge
  task automatic cycle();
    bit     acc, hs;
    exp_t   e, n;
    longint ae;
    @(negedge clk);
    last_in_ready = in_ready;
    check("in_ready", 64'(in_ready), 64'(!rst && (!out_valid || out_ready)));
    if (holding) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", 64'(out_sum), 64'(hold_sum));
      check("stall_exact", 64'(out_exact), 64'(hold_exact));
    end
    holding    = out_valid && !out_ready && !rst;
    hold_sum   = out_sum;
    hold_exact = out_exact;
    acc = in_valid && in_ready && !rst;
    hs  = out_valid && out_ready && !rst;
    last_acc = acc;
    if (hs) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed=%0h expected=none", out_sum);
      end
      if (q.size() != 0) begin
        e  = q.pop_front();
        recv++;
        check("out_sum", 64'(out_sum), e.sum);
        check("out_exact", 64'(out_exact), e.exact);
        check("out_err", 64'(out_err), 64'(e.sum != e.exact));
        ae = (e.exact >= e.sum) ? e.exact - e.sum : e.sum - e.exact;
        if (!stat_clear) begin
          m_samples = sat_add(m_samples, 1);
          m_errcnt  = sat_add(m_errcnt, (e.sum != e.exact) ? 1 : 0);
          m_sumerr  = sat_add(m_sumerr, ae);
          if (ae > m_maxerr) m_maxerr = ae;
        end
      end
    end
    if (acc) begin
      n.sum   = ref_sum(int'(mode), int'(k), longint'(a), longint'(b));
      n.exact = longint'(a) + longint'(b);
      q.push_back(n);
    end
    if (stat_clear || rst) begin
      m_samples = 0; m_errcnt = 0; m_sumerr = 0; m_maxerr = 0;
    end
    if (rst) q.delete();
    @(posedge clk);
    #1;
    if (chk_stats) begin
      check("stat_samples", 64'(samples), m_samples);
      check("stat_err_cnt", 64'(err_cnt), m_errcnt);
      check("stat_sum_err", 64'(sum_err), m_sumerr);
      check("stat_max_err", 64'(max_err), m_maxerr);
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && q.size() != 0; n++) cycle();
    check(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int sent, c, rc;
    rst = 1'b1; out_ready = 1'b1; stat_clear = 1'b0;
    drive(0, 0, 0, 0, 0);
    cycle(); cycle();
    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_exact", 64'(out_exact), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    cycle();

    // 1: mode0 carry out, latency PIPE
    drive(1, 0, 0, 'hFFFF, 'h0001);
    cycle();
    drive(0, 0, 0, 0, 0);
    check("t1_valid_early", 64'(out_valid), 64'd0);
    cycle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_sum", 64'(out_sum), 64'h10000);
    check("t1_exact", 64'(out_exact), 64'h10000);
    check("t1_err", 64'(out_err), 64'd0);
    drain("t1_drain");

    // 2: mode1 k=4
    stat_clear = 1'b1; cycle(); stat_clear = 1'b0;
    drive(1, 1, 4, 'h000F, 'h0001);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    check("t2_sum", 64'(out_sum), 64'h000F);
    check("t2_exact", 64'(out_exact), 64'h0010);
    check("t2_err", 64'(out_err), 64'd1);
    drain("t2_drain");
    cycle();
    check("t2_max_err", 64'(max_err), 64'd1);
    check("t2_err_cnt", 64'(err_cnt), 64'd1);

    // 3: mode2 then mode3, k=8
    stat_clear = 1'b1; cycle(); stat_clear = 1'b0;
    drive(1, 2, 8, 'h12FF, 'h0101);
    cycle();
    drive(1, 3, 8, 'h00FF, 'h0001);
    cycle();
    drive(0, 0, 0, 0, 0);
    check("t3_sum_a", 64'(out_sum), 64'h1300);
    check("t3_exact_a", 64'(out_exact), 64'h1400);
    cycle();
    check("t3_sum_b", 64'(out_sum), 64'h0000);
    check("t3_exact_b", 64'(out_exact), 64'h0100);
    drain("t3_drain");
    cycle();
    check("t3_max_err", 64'(max_err), 64'h0100);
    check("t3_sum_err", 64'(sum_err), 64'h0200);

    // 4: 20 random back-to-back pairs, out_ready low for stream cycles 5..9
    stat_clear = 1'b1; cycle(); stat_clear = 1'b0;
    recv = 0; sent = 0; c = 0;
    drive(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), longint'($urandom), longint'($urandom));
    while ((sent < 20 || q.size() != 0) && c < 200) begin
      out_ready = !(c >= 5 && c <= 9);
      cycle();
      if (c >= 5 && c <= 9) check("t4_in_ready_stall", 64'(last_in_ready), 64'd0);
      if (last_acc) begin
        sent++;
        if (sent < 20)
          drive(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), longint'($urandom), longint'($urandom));
        else
          drive(0, 0, 0, 0, 0);
      end
      c++;
    end
    out_ready = 1'b1;
    check("t4_recv", 64'(recv), 64'd20);
    check("t4_samples", 64'(samples), 64'd20);

    // 5: clear coincident with a handshake, then saturate the error sum
    out_ready = 1'b0;
    drive(1, 1, 4, 'h000F, 'h0001);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle(); cycle();
    check("t5_stalled_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; stat_clear = 1'b1;
    cycle();
    stat_clear = 1'b0;
    check("t5_clr_samples", 64'(samples), 64'd0);
    check("t5_clr_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_clr_max_err", 64'(max_err), 64'd0);
    check("t5_clr_sum_err", 64'(sum_err), 64'd0);
    chk_stats = 1'b0;
    drive(1, 2, 16, 'hFFFF, 'hFFFF);
    for (int n = 0; n < 32800; n++) cycle();
    drive(0, 0, 0, 0, 0);
    drain("t5_drain");
    chk_stats = 1'b1;
    cycle();
    check("t5_sat_sum_err", 64'(sum_err), 64'hFFFF_FFFF);
    check("t5_sat_samples", 64'(samples), 64'd32800);
    check("t5_sat_max_err", 64'(max_err), 64'h1FFFE);

    // 6: reset with two samples in flight
    drive(1, 3, 5, longint'($urandom), longint'($urandom));
    cycle();
    drive(1, 1, 7, longint'($urandom), longint'($urandom));
    cycle();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_samples", 64'(samples), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    rc = recv;
    drive(1, 1, 3, 'h1234, 'h0F0F);
    cycle();
    drive(0, 0, 0, 0, 0);
    check("t6_valid_early", 64'(out_valid), 64'd0);
    cycle();
    check("t6_valid_late", 64'(out_valid), 64'd1);
    check("t6_sum", 64'(out_sum), ref_sum(1, 3, 'h1234, 'h0F0F));
    drain("t6_drain");
    check("t6_recv", 64'(recv - rc), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
